// File: rtl/clock_monitor_pkg.sv
// Shared types, default parameters and arithmetic helpers for the clock monitor.
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } mon_state_t;

  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned DEF_MIN_HALF = 2;
  localparam int unsigned DEF_TIMEOUT  = 1024;

  // Unsigned add clamped to the largest value representable in w bits (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/clock_monitor_if.sv
// Monitored input, clear control and measurement results of the clock monitor.
interface clock_monitor_if
  import clock_monitor_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic             mon_in;
  logic             clear;
  logic             meas_valid;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             glitch;
  logic             lost;

  modport master (
    output mon_in, clear,
    input  meas_valid, period, high_time, glitch, lost
  );

  modport slave (
    input  mon_in, clear,
    output meas_valid, period, high_time, glitch, lost
  );
endinterface

// File: rtl/clock_monitor_sync2.sv
// Two-flop synchroniser for a single asynchronous bit, synchronous reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/clock_monitor.sv
// Resynchronises a clock-like input, measures high time and period in system
// cycles, and flags short half-periods (sticky) and loss of activity.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned MIN_HALF = DEF_MIN_HALF,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic           clk_in,
  input  logic           rst,
  clock_monitor_if.slave mon
);
  logic             s1;
  logic             s_prev_d, s_prev_q;
  logic [CNT_W-1:0] half_cnt_d, half_cnt_q;
  logic [CNT_W-1:0] high_len_d, high_len_q;
  logic [CNT_W-1:0] period_d, period_q;
  logic [CNT_W-1:0] high_time_d, high_time_q;
  logic             meas_valid_d, meas_valid_q;
  logic             glitch_d, glitch_q;
  logic             lost_d, lost_q;
  mon_state_t       state_d, state_q;

  logic rise, fall, any_edge, timeout, new_glitch;

  sync2 u_sync (
    .clk (clk_in),
    .rst (rst),
    .d   (mon.mon_in),
    .q   (s1)
  );

  always_comb begin
    rise     = s1 & ~s_prev_q;
    fall     = ~s1 & s_prev_q;
    any_edge = rise | fall;
    // Only reachable while the counter still measures the current half;
    // a same-cycle edge takes precedence over the timeout.
    timeout  = (32'(half_cnt_q) == TIMEOUT) && !any_edge;

    s_prev_d     = s1;
    half_cnt_d   = any_edge ? CNT_W'(1)
                            : CNT_W'(sat_add(32'(half_cnt_q), 32'd1, CNT_W));
    state_d      = state_q;
    high_len_d   = high_len_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    lost_d       = lost_q;
    new_glitch   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          lost_d  = 1'b0;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          high_len_d = half_cnt_q;
          new_glitch = (32'(half_cnt_q) < MIN_HALF);
          state_d    = ST_LOW;
        end else if (timeout) begin
          lost_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (rise) begin
          new_glitch   = (32'(half_cnt_q) < MIN_HALF);
          high_time_d  = high_len_q;
          period_d     = CNT_W'(sat_add(32'(high_len_q), 32'(half_cnt_q), CNT_W));
          meas_valid_d = 1'b1;
          state_d      = ST_HIGH;
        end else if (timeout) begin
          lost_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    glitch_d = new_glitch ? 1'b1 : (mon.clear ? 1'b0 : glitch_q);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      s_prev_q     <= 1'b0;
      half_cnt_q   <= '0;
      high_len_q   <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      glitch_q     <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_prev_q     <= s_prev_d;
      half_cnt_q   <= half_cnt_d;
      high_len_q   <= high_len_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      glitch_q     <= glitch_d;
      lost_q       <= lost_d;
    end
  end

  assign mon.meas_valid = meas_valid_q;
  assign mon.period     = period_q;
  assign mon.high_time  = high_time_q;
  assign mon.glitch     = glitch_q;
  assign mon.lost       = lost_q;
endmodule
